// File: rtl/light_phase_timer.sv
// Phase timer and pedestrian-request front end for the traffic light controller.
// Optional secs_left countdown output is enabled by defining LIGHT_PHASE_TIMER_SECS_LEFT_EN.
module light_phase_timer #(
  parameter int CLK_DIV       = 50_000_000,
  parameter int DIV_W         = 26,
  parameter int RED_SEC       = 6,
  parameter int GREEN_SEC     = 4,
  parameter int YELLOW_SEC    = 2,
  parameter int MIN_GREEN_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       green,
  input  logic       yellow,
  input  logic       ped_button,
  output logic       max_r,
  output logic       max_g,
  output logic       max_y,
  output logic       pedestrian,
`ifdef LIGHT_PHASE_TIMER_SECS_LEFT_EN
  output logic [3:0] secs_left,
`endif
  output logic       sec_tick
);

  typedef enum logic [1:0] {PH_NONE, PH_R, PH_G, PH_Y} phase_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       MIN_G    = 4'(MIN_GREEN_SEC);

  function automatic logic [3:0] dur_of(input phase_t p);
    case (p)
      PH_R:    dur_of = 4'(RED_SEC);
      PH_G:    dur_of = 4'(GREEN_SEC);
      PH_Y:    dur_of = 4'(YELLOW_SEC);
      default: dur_of = 4'd0;
    endcase
  endfunction

  phase_t           phase_d, phase_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       elapsed_q, elapsed_d, dur_q;
  logic [1:0]       sync_q;
  logic             btn_q, req_q, req_d;
  logic             change, active, wrap, rise, out_of_g, ped_d;
  logic             max_r_d, max_g_d, max_y_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    phase_d = PH_NONE;
    case ({red, green, yellow})
      3'b100:  phase_d = PH_R;
      3'b010:  phase_d = PH_G;
      3'b001:  phase_d = PH_Y;
      default: phase_d = PH_NONE;
    endcase
  end

  always_comb begin
    change    = (phase_d != phase_q);
    active    = (phase_d != PH_NONE) && !change;
    wrap      = active && (div_q == DIV_LAST);
    dur_q     = dur_of(phase_q);
    div_d     = '0;
    elapsed_d = '0;
    if (active) begin
      div_d     = wrap ? '0 : div_q + DIV_W'(1);
      elapsed_d = (wrap && elapsed_q < dur_q) ? elapsed_q + 4'd1 : elapsed_q;
    end
    // Flags follow the next elapsed value so they rise together with the final tick.
    max_r_d = active && (phase_q == PH_R) && (elapsed_d == dur_q);
    max_g_d = active && (phase_q == PH_G) && (elapsed_d == dur_q);
    max_y_d = active && (phase_q == PH_Y) && (elapsed_d == dur_q);

    rise     = sync_q[1] && !btn_q;
    out_of_g = (phase_q == PH_G) && (phase_d != PH_G);
    req_d    = req_q;
    if (out_of_g)
      req_d = 1'b0;
    else if (rise && !change && (phase_q == PH_G || phase_q == PH_Y))
      req_d = 1'b1;
    ped_d = req_q && (phase_q == PH_G) && !change && (elapsed_q >= MIN_G);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and clears all state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_NONE;
      div_q      <= '0;
      elapsed_q  <= '0;
      sync_q     <= '0;
      btn_q      <= 1'b0;
      req_q      <= 1'b0;
      max_r      <= 1'b0;
      max_g      <= 1'b0;
      max_y      <= 1'b0;
      pedestrian <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      div_q      <= div_d;
      elapsed_q  <= elapsed_d;
      sync_q     <= {sync_q[0], ped_button};
      btn_q      <= sync_q[1];
      req_q      <= req_d;
      max_r      <= max_r_d;
      max_g      <= max_g_d;
      max_y      <= max_y_d;
      pedestrian <= ped_d;
      sec_tick   <= wrap;
    end
  end

`ifdef LIGHT_PHASE_TIMER_SECS_LEFT_EN
  // A phase change clears elapsed, so the new phase starts at its full duration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      secs_left <= '0;
    else if (phase_d == PH_NONE)
      secs_left <= '0;
    else
      secs_left <= dur_of(phase_d) - elapsed_d;
  end
`endif

endmodule
